sparse_block_feeder: RTL and testbench
======================================

# sparse_block_feeder

Drives the sparse systolic array's input side: `block_valid`, `load_weight`, `a_in_flat` and `b_in_flat`. It consumes a stream of block descriptors from the sparse scheduler. For each nonzero block it reads N_ROWS weight rows from the weight buffer, then K_STEPS activation vectors from the activation buffer, and streams them into the array in the order the array expects. All-zero blocks are retired in one cycle with no buffer reads and no array activity (skip-zero).

## Interface
- N_ROWS, 16, array rows; weight rows loaded per block
- N_COLS, 16, array columns
- DATA_W, 8, element width
- K_STEPS, 16, activation vectors streamed per block (≥1)
- ADDR_W, 10, buffer address width
- clk  in  1  clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- blk_valid  in  1  descriptor valid
- blk_ready  out  1  descriptor accepted when blk_valid && blk_ready
- blk_zero  in  1  block is all-zero; skip it
- blk_last  in  1  last block of the tile
- blk_wgt_base  in  ADDR_W  weight-buffer row base
- blk_act_base  in  ADDR_W  activation-buffer base
- wgt_rd_en  out  1  weight read strobe
- wgt_rd_addr  out  ADDR_W  weight read address
- wgt_rd_data  in  N_COLS*DATA_W  weight row; valid exactly 1 cycle after strobe
- act_rd_en  out  1  activation read strobe
- act_rd_addr  out  ADDR_W  activation read address
- act_rd_data  in  N_ROWS*DATA_W  activation vector; 1-cycle latency
- load_weight  out  1  to array
- block_valid  out  1  to array (PE enable)
- b_in_flat  out  N_COLS*DATA_W  to array
- a_in_flat  out  N_ROWS*DATA_W  to array
- busy  out  1  state ≠ IDLE, or the read pipe is non-empty
- tile_done  out  1  one-cycle pulse after the last block drains
- stat_active  out  16  nonzero blocks processed; wraps
- stat_skipped  out  16  zero blocks skipped; wraps

## Operation
- States:
  - IDLE: blk_ready=1.
  - LOAD_W: N_ROWS cycles.
  - STREAM: K_STEPS cycles.
  - No other states.
- IDLE, accepting blk_zero=1: stat_skipped++ and stay in IDLE.
  - If blk_last is set, tile_done pulses on the next cycle.
- IDLE, accepting blk_zero=0:
  - Latch the bases and the last flag, clear row_cnt, go to LOAD_W.
- LOAD_W:
  - wgt_rd_en=1, wgt_rd_addr = wgt_base + row_cnt.
  - Exit after row_cnt = N_ROWS-1 and go to STREAM.
- STREAM:
  - act_rd_en=1, act_rd_addr = act_base + step_cnt.
  - Exit after step_cnt = K_STEPS-1: stat_active++ and return to IDLE.
- Read alignment:
  - load_weight = registered wgt_rd_en; b_in_flat = wgt_rd_data captured under that flag.
  - block_valid = registered act_rd_en; a_in_flat = act_rd_data under that flag.
- When their flag is low, a_in_flat and b_in_flat are 0.
- load_weight and block_valid are never high in the same cycle.
- Address arithmetic is modulo 2^ADDR_W; wrap is permitted.
- tile_done for an active last block fires in the cycle after its final block_valid.

## Timing
- Reset: all outputs 0, except blk_ready=1; state IDLE; counters 0; read pipe flushed.
- Reset mid-block: the block is abandoned and nothing is counted.
- Nonzero block accepted at cycle 0:
  - wgt_rd_en high cycles 1..N_ROWS.
  - load_weight high cycles 2..N_ROWS+1; row r is presented at cycle r+2.
  - act_rd_en high cycles N_ROWS+1..N_ROWS+K_STEPS.
  - block_valid high cycles N_ROWS+2..N_ROWS+K_STEPS+1.
  - blk_ready returns high at cycle N_ROWS+K_STEPS+1.
- Block occupancy: 1+N_ROWS+K_STEPS cycles; a zero block costs 1 cycle.
- Back-to-back blocks: at least K_STEPS cycles of load_weight low separate consecutive weight phases, so the array's row pointer resets between blocks.
- blk_* inputs are sampled only on handshake; blk_valid may drop without acceptance.

## Structure
- Package sparse_feeder_pkg holds:
  - the state enum {IDLE, LOAD_W, STREAM};
  - the localparam read latency RD_LAT=1.
- One sub-module, feeder_rd_align: the 1-stage strobe/data register that produces load_weight/b_in_flat and block_valid/a_in_flat, including zero-forcing.
- Counters and the FSM stay in sparse_block_feeder.

## Test plan
- Single nonzero block, wgt_base=0x10, act_base=0x40, N_ROWS=K_STEPS=16, last=1:
  - wgt addrs 0x10..0x1F;
  - load_weight cycles 2..17;
  - block_valid cycles 18..33;
  - tile_done at 34;
  - stat_active=1.
- Three zero blocks back-to-back, last on the third:
  - blk_ready stays 1 and no rd_en;
  - stat_skipped=3;
  - tile_done 1 cycle after the third handshake.
- Interleaved zero/nonzero/zero/nonzero, blk_valid always high:
  - total cycles = 2*33+2;
  - load_weight and block_valid never overlap;
  - a_in_flat and b_in_flat are 0 whenever their flag is low.
- wgt_base=0x3FC with ADDR_W=10: addresses wrap 0x3FC..0x3FF, 0x000..0x00B.
- rst_n asserted at cycle 8 of LOAD_W:
  - all outputs 0 at once;
  - stat_active unchanged at 0;
  - a new descriptor after reset runs a full block.
- Scoreboard against the array model:
  - random weights and activations for 4 blocks;
  - c_out equals the reference sum of the nonzero blocks only.

Source files
------------

// File: rtl/sparse_feeder_pkg.sv
// Shared types and constants for the sparse block feeder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sparse_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2
  } feeder_state_e;

  // Cycles from a buffer read strobe to its data appearing on rd_data.
  localparam int RD_LAT = 1;

endpackage

// File: rtl/feeder_rd_align.sv
// Aligns buffer read strobes with returning data and presents them to the array.
// Latency: RD_LAT cycles from rd_en to load_weight/block_valid; data passes through combinationally.
// Backpressure: none; the array must accept every presented row/vector.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wgt_rd_en, wgt_rd_data      weight strobe and the buffer's returned row
//   act_rd_en, act_rd_data      activation strobe and the buffer's returned vector
//   load_weight, b_in_flat      weight row to the array (zero when not loading)
//   block_valid, a_in_flat      activation vector to the array (zero when not valid)
module feeder_rd_align
  import sparse_feeder_pkg::*;
#(
  parameter int N_ROWS = 16,
  parameter int N_COLS = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wgt_rd_en,
  input  logic [N_COLS*DATA_W-1:0] wgt_rd_data,
  input  logic                     act_rd_en,
  input  logic [N_ROWS*DATA_W-1:0] act_rd_data,
  output logic                     load_weight,
  output logic [N_COLS*DATA_W-1:0] b_in_flat,
  output logic                     block_valid,
  output logic [N_ROWS*DATA_W-1:0] a_in_flat
);

  // Strobe delay lines; the oldest stage marks the cycle the buffer data is valid.
  logic [RD_LAT-1:0] wgt_pipe;
  logic [RD_LAT-1:0] act_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wgt_pipe <= '0;
      act_pipe <= '0;
    end else begin
      wgt_pipe[0] <= wgt_rd_en;
      act_pipe[0] <= act_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        wgt_pipe[i] <= wgt_pipe[i-1];
        act_pipe[i] <= act_pipe[i-1];
      end
    end
  end

  assign load_weight = wgt_pipe[RD_LAT-1];
  assign block_valid = act_pipe[RD_LAT-1];

  // The buffers return garbage between reads; force the array inputs to zero then.
  assign b_in_flat = load_weight ? wgt_rd_data : '0;
  assign a_in_flat = block_valid ? act_rd_data : '0;

endmodule

// File: rtl/sparse_block_feeder.sv
// Streams weight rows then activation vectors of each nonzero block into the systolic array; zero blocks retire in one cycle.
// Latency: nonzero block occupies 1+N_ROWS+K_STEPS cycles, array sees data RD_LAT after each read; zero block 1 cycle.
// Backpressure: blk_ready is high only in IDLE; downstream array cannot stall the feeder.
//
// Ports:
//   clk, rst_n                                   clock, async active-low reset
//   blk_valid/blk_ready, blk_zero, blk_last,
//   blk_wgt_base, blk_act_base                   block descriptor handshake from the scheduler
//   wgt_rd_en/addr/data, act_rd_en/addr/data     weight and activation buffer read ports
//   load_weight, b_in_flat, block_valid, a_in_flat   array input side
//   busy, tile_done, stat_active, stat_skipped   status and wrapping block counters
module sparse_block_feeder
  import sparse_feeder_pkg::*;
#(
  parameter int N_ROWS  = 16,
  parameter int N_COLS  = 16,
  parameter int DATA_W  = 8,
  parameter int K_STEPS = 16,
  parameter int ADDR_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  input  logic                     blk_zero,
  input  logic                     blk_last,
  input  logic [ADDR_W-1:0]        blk_wgt_base,
  input  logic [ADDR_W-1:0]        blk_act_base,
  output logic                     wgt_rd_en,
  output logic [ADDR_W-1:0]        wgt_rd_addr,
  input  logic [N_COLS*DATA_W-1:0] wgt_rd_data,
  output logic                     act_rd_en,
  output logic [ADDR_W-1:0]        act_rd_addr,
  input  logic [N_ROWS*DATA_W-1:0] act_rd_data,
  output logic                     load_weight,
  output logic                     block_valid,
  output logic [N_COLS*DATA_W-1:0] b_in_flat,
  output logic [N_ROWS*DATA_W-1:0] a_in_flat,
  output logic                     busy,
  output logic                     tile_done,
  output logic [15:0]              stat_active,
  output logic [15:0]              stat_skipped
);

  localparam int ROW_W  = (N_ROWS  > 1) ? $clog2(N_ROWS)  : 1;
  localparam int STEP_W = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(N_ROWS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(K_STEPS - 1);

  feeder_state_e state, state_nxt;

  logic [ROW_W-1:0]  row_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [ADDR_W-1:0] wgt_base;
  logic [ADDR_W-1:0] act_base;
  logic              last_q;
  logic              last_exit_q;
  logic              tile_done_q;
  logic              blk_fire;
  logic              row_end;
  logic              step_end;

  assign blk_fire = blk_valid && blk_ready;
  assign row_end  = (row_cnt == ROW_LAST);
  assign step_end = (step_cnt == STEP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    blk_ready = 1'b0;
    wgt_rd_en = 1'b0;
    act_rd_en = 1'b0;
    case (state)
      IDLE: begin
        blk_ready = 1'b1;
        // Zero blocks are retired right here without leaving IDLE.
        if (blk_valid && !blk_zero) state_nxt = LOAD_W;
      end
      LOAD_W: begin
        wgt_rd_en = 1'b1;
        if (row_end) state_nxt = STREAM;
      end
      STREAM: begin
        act_rd_en = 1'b1;
        if (step_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses wrap naturally at 2^ADDR_W.
  assign wgt_rd_addr = wgt_base + ADDR_W'(row_cnt);
  assign act_rd_addr = act_base + ADDR_W'(step_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt      <= '0;
      step_cnt     <= '0;
      wgt_base     <= '0;
      act_base     <= '0;
      last_q       <= 1'b0;
      last_exit_q  <= 1'b0;
      tile_done_q  <= 1'b0;
      stat_active  <= '0;
      stat_skipped <= '0;
    end else begin
      if (blk_fire && !blk_zero) begin
        wgt_base <= blk_wgt_base;
        act_base <= blk_act_base;
        last_q   <= blk_last;
        row_cnt  <= '0;
        step_cnt <= '0;
      end
      if (state == LOAD_W) row_cnt <= row_cnt + ROW_W'(1);
      if (state == STREAM) begin
        step_cnt <= step_cnt + STEP_W'(1);
        if (step_end) stat_active <= stat_active + 16'd1;
      end
      if (blk_fire && blk_zero) stat_skipped <= stat_skipped + 16'd1;
      // Active last block: one stage to cover the read latency, one more so the
      // pulse lands after the final block_valid.
      last_exit_q <= (state == STREAM) && step_end && last_q;
      tile_done_q <= last_exit_q || (blk_fire && blk_zero && blk_last);
    end
  end

  assign tile_done = tile_done_q;

  feeder_rd_align #(
    .N_ROWS (N_ROWS),
    .N_COLS (N_COLS),
    .DATA_W (DATA_W)
  ) u_rd_align (
    .clk         (clk),
    .rst_n       (rst_n),
    .wgt_rd_en   (wgt_rd_en),
    .wgt_rd_data (wgt_rd_data),
    .act_rd_en   (act_rd_en),
    .act_rd_data (act_rd_data),
    .load_weight (load_weight),
    .b_in_flat   (b_in_flat),
    .block_valid (block_valid),
    .a_in_flat   (a_in_flat)
  );

  // Busy covers the read pipe too, so it stays high through the last presented vector.
  assign busy = (state != IDLE) || load_weight || block_valid;

endmodule

// File: tb/tb_sparse_block_feeder.sv
// Scoreboard bench for sparse_block_feeder with behavioural buffers and array model.
// Latency: checks exact presentation cycles of every read, row, vector and tile_done.
// Backpressure: descriptors are offered and held until blk_ready.
module tb_sparse_block_feeder;

  localparam int N  = 16;
  localparam int K  = 16;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int RW = N * DW;

  logic          clk;
  logic          rst_n;
  logic          blk_valid, blk_ready, blk_zero, blk_last;
  logic [AW-1:0] blk_wgt_base, blk_act_base;
  logic          wgt_rd_en, act_rd_en;
  logic [AW-1:0] wgt_rd_addr, act_rd_addr;
  logic [RW-1:0] wgt_rd_data, act_rd_data;
  logic          load_weight, block_valid;
  logic [RW-1:0] b_in_flat, a_in_flat;
  logic          busy, tile_done;
  logic [15:0]   stat_active, stat_skipped;

  sparse_block_feeder #(
    .N_ROWS(N), .N_COLS(N), .DATA_W(DW), .K_STEPS(K), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_zero(blk_zero), .blk_last(blk_last),
    .blk_wgt_base(blk_wgt_base), .blk_act_base(blk_act_base),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .load_weight(load_weight), .block_valid(block_valid),
    .b_in_flat(b_in_flat), .a_in_flat(a_in_flat),
    .busy(busy), .tile_done(tile_done),
    .stat_active(stat_active), .stat_skipped(stat_skipped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffers: random garbage on the data bus whenever no read was issued.
  logic [RW-1:0] wmem [1024];
  logic [RW-1:0] amem [1024];

  function automatic logic [RW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) begin
    wgt_rd_data <= wgt_rd_en ? wmem[wgt_rd_addr] : rnd128();
    act_rd_data <= act_rd_en ? amem[act_rd_addr] : rnd128();
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    int            cyc;
    logic [RW-1:0] dat;
  } exp_t;

  exp_t q_wa[$];  // weight read address
  exp_t q_wd[$];  // weight row presented to the array
  exp_t q_ad[$];  // activation vector presented to the array
  exp_t q_td[$];  // tile_done pulses

  int exp_active  = 0;
  int exp_skipped = 0;

  // Array model: weight rows fill a row pointer that rewinds while load_weight is low.
  logic [RW-1:0] warr [N];
  int            wptr = 0;
  logic [31:0]   acc     [N];
  logic [31:0]   ref_acc [N];

  always @(negedge clk) begin
    exp_t e;
    check("load_weight/block_valid overlap", {127'd0, load_weight & block_valid}, 0);
    if (!load_weight) check("b_in_flat while idle", b_in_flat, 0);
    if (!block_valid) check("a_in_flat while idle", a_in_flat, 0);
    if (rst_n) begin
      if (wgt_rd_en) begin
        if (q_wa.size() == 0) check("unexpected wgt_rd_en", {127'd0, wgt_rd_en}, 0);
        else begin
          e = q_wa.pop_front();
          check("wgt_rd cycle", cyc, e.cyc);
          check("wgt_rd_addr", {118'd0, wgt_rd_addr}, e.dat);
        end
      end
      if (load_weight) begin
        if (q_wd.size() == 0) check("unexpected load_weight", {127'd0, load_weight}, 0);
        else begin
          e = q_wd.pop_front();
          check("load_weight cycle", cyc, e.cyc);
          check("b_in_flat", b_in_flat, e.dat);
        end
      end
      if (block_valid) begin
        if (q_ad.size() == 0) check("unexpected block_valid", {127'd0, block_valid}, 0);
        else begin
          e = q_ad.pop_front();
          check("block_valid cycle", cyc, e.cyc);
          check("a_in_flat", a_in_flat, e.dat);
        end
      end
      if (tile_done) begin
        if (q_td.size() == 0) check("unexpected tile_done", {127'd0, tile_done}, 0);
        else begin
          e = q_td.pop_front();
          check("tile_done cycle", cyc, e.cyc);
        end
      end
    end
    if (load_weight) begin
      if (wptr < N) warr[wptr] = b_in_flat;
      wptr++;
    end else begin
      wptr = 0;
    end
    if (block_valid)
      for (int c = 0; c < N; c++)
        for (int r = 0; r < N; r++)
          acc[c] += 32'(a_in_flat[r*DW +: DW]) * 32'(warr[r][c*DW +: DW]);
  end

  // Offers one descriptor; h returns the handshake cycle (cycle 0 of the block).
  task automatic send(input bit z, input bit l, input logic [AW-1:0] wb,
                      input logic [AW-1:0] ab, output int h);
    int t = 0;
    @(negedge clk);
    blk_valid = 1'b1; blk_zero = z; blk_last = l;
    blk_wgt_base = wb; blk_act_base = ab;
    while (!blk_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    h = cyc;
    if (!blk_ready) begin
      check("descriptor handshake timeout", {127'd0, blk_ready}, 1);
      blk_valid = 1'b0;
      return;
    end
    if (z) begin
      exp_skipped++;
      if (l) q_td.push_back('{cyc: h + 1, dat: '0});
    end else begin
      for (int r = 0; r < N; r++) begin
        logic [AW-1:0] wa;
        wa = wb + AW'(r);
        q_wa.push_back('{cyc: h + 1 + r, dat: RW'(wa)});
        q_wd.push_back('{cyc: h + 2 + r, dat: wmem[wa]});
      end
      for (int k = 0; k < K; k++) begin
        logic [AW-1:0] aa;
        aa = ab + AW'(k);
        q_ad.push_back('{cyc: h + N + 2 + k, dat: amem[aa]});
        for (int c = 0; c < N; c++)
          for (int r = 0; r < N; r++)
            ref_acc[c] += 32'(amem[aa][r*DW +: DW]) * 32'(wmem[wb + AW'(r)][c*DW +: DW]);
      end
      if (l) q_td.push_back('{cyc: h + N + K + 2, dat: '0});
      exp_active++;
    end
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    if (z) check("blk_ready after zero block", {127'd0, blk_ready}, 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((q_wa.size() + q_wd.size() + q_ad.size() + q_td.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("drain busy", {127'd0, busy}, 0);
    check("drain pending expectations", q_wa.size() + q_wd.size() + q_ad.size() + q_td.size(), 0);
    check("stat_active", {112'd0, stat_active}, exp_active);
    check("stat_skipped", {112'd0, stat_skipped}, exp_skipped);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " blk_ready"},   {127'd0, blk_ready}, 1);
    check({tag, " wgt_rd_en"},   {127'd0, wgt_rd_en}, 0);
    check({tag, " act_rd_en"},   {127'd0, act_rd_en}, 0);
    check({tag, " wgt_rd_addr"}, {118'd0, wgt_rd_addr}, 0);
    check({tag, " act_rd_addr"}, {118'd0, act_rd_addr}, 0);
    check({tag, " load_weight"}, {127'd0, load_weight}, 0);
    check({tag, " block_valid"}, {127'd0, block_valid}, 0);
    check({tag, " b_in_flat"},   b_in_flat, 0);
    check({tag, " a_in_flat"},   a_in_flat, 0);
    check({tag, " busy"},        {127'd0, busy}, 0);
    check({tag, " tile_done"},   {127'd0, tile_done}, 0);
    check({tag, " stat_active"}, {112'd0, stat_active}, 0);
    check({tag, " stat_skipped"}, {112'd0, stat_skipped}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int h, h0;
    int t;
    rst_n = 1'b0;
    blk_valid = 1'b0; blk_zero = 1'b0; blk_last = 1'b0;
    blk_wgt_base = '0; blk_act_base = '0;
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = rnd128();
      amem[i] = rnd128();
    end
    for (int c = 0; c < N; c++) begin
      acc[c] = '0;
      ref_acc[c] = '0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // Single nonzero last block.
    send(0, 1, 10'h010, 10'h040, h);
    drain();

    // Three zero blocks back to back, last on the third.
    send(1, 0, 10'h123, 10'h234, h);
    send(1, 0, 10'h111, 10'h222, h);
    send(1, 1, 10'h000, 10'h000, h);
    drain();

    // Interleaved zero / nonzero / zero / nonzero with descriptors always offered.
    send(1, 0, 10'h050, 10'h060, h0);
    send(0, 0, 10'h070, 10'h080, h);
    send(1, 0, 10'h090, 10'h0A0, h);
    send(0, 1, 10'h0B0, 10'h0C0, h);
    t = 0;
    while (!blk_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("interleaved total cycles", cyc - h0, 2 * 33 + 2);
    drain();

    // Address wrap on both buffers.
    send(0, 0, 10'h3FC, 10'h3FE, h);
    drain();

    // Reset in cycle 8 of LOAD_W abandons the block.
    send(0, 0, 10'h100, 10'h200, h);
    while (cyc < h + 8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q_wa.delete(); q_wd.delete(); q_ad.delete(); q_td.delete();
    exp_active = 0;
    exp_skipped = 0;
    #1;
    check_idle("mid-block reset");
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 1, 10'h100, 10'h200, h);
    drain();

    // Array model: accumulated result over four blocks counts only the nonzero ones.
    for (int c = 0; c < N; c++) begin
      acc[c] = '0;
      ref_acc[c] = '0;
    end
    send(0, 0, 10'h020, 10'h080, h);
    send(1, 0, 10'h300, 10'h300, h);
    send(0, 0, 10'h0A0, 10'h150, h);
    send(0, 1, 10'h3F8, 10'h3F0, h);
    drain();
    for (int c = 0; c < N; c++) check($sformatf("c_out[%0d]", c), {96'd0, acc[c]}, {96'd0, ref_acc[c]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
